aes_batch_sequencer: RTL and testbench
======================================

Name: aes_batch_sequencer

Overview:
- Sits between usb_reg and aes_core in the DUT clock domain.
- Runs a programmed batch of N back-to-back AES-128 encryptions with a programmable idle gap between them, for automated trace capture.
- Sequences aes_core load/busy, selects the next plaintext (fixed, chained or incrementing), counts completions, captures the last ciphertext and drives the capture trigger.

Parameters:
pCNT_WIDTH, 16, width of batch count and completion counter
pGAP_WIDTH, 16, width of inter-encryption gap (dut_clk cycles)
pTIMEOUT, 64, max cycles from aes_load until aes_busy must rise

Ports:
dut_clk  input  1  DUT clock; all logic on rising edge
dut_rst_n  input  1  asynchronous active-low reset
cfg_start  input  1  start pulse; sampled only in IDLE
cfg_abort  input  1  abort request; level, sampled every cycle
cfg_count  input  pCNT_WIDTH  number of encryptions in the batch
cfg_gap  input  pGAP_WIDTH  idle cycles between encryptions
cfg_mode  input  2  0=fixed pt, 1=chain (pt<=ct), 2=increment pt, 3=reserved (treated as 0)
cfg_key  input  128  AES-128 key
cfg_pt  input  128  initial plaintext
aes_load  output  1  load pulse to aes_core
aes_key  output  256  {key_latched, 128'h0}
aes_din  output  128  current plaintext to aes_core
aes_dout  input  128  aes_core ciphertext
aes_busy  input  1  aes_core busy
seq_busy  output  1  high whenever state != IDLE
seq_done  output  1  one-cycle pulse on normal batch completion
seq_error  output  1  sticky timeout flag; cleared by next accepted start
trig_out  output  1  capture trigger; high while state == RUN
enc_count  output  pCNT_WIDTH  completed encryptions this batch
last_ct  output  128  ciphertext of most recent completed encryption

Behaviour:
- Reset values: aes_load=0, aes_key=0, aes_din=0, seq_busy=0, seq_done=0, seq_error=0, trig_out=0, enc_count=0, last_ct=0, state=IDLE, gap and timeout counters=0.
- States: IDLE, LOAD, WAIT_BUSY, RUN, GAP, DRAIN.
- IDLE: cfg_start=1 and cfg_abort=0 latches count, gap, mode (3->0), key and pt; clears enc_count and seq_error; goes to LOAD. If the latched count is 0, goes directly to IDLE and pulses seq_done the next cycle, with enc_count=0.
- cfg_start is ignored outside IDLE. cfg_abort wins over cfg_start in the same cycle.
- LOAD: aes_load=1 for exactly this one cycle, aes_din=current pt held stable; clears the timeout counter; goes to WAIT_BUSY.
- WAIT_BUSY: aes_busy=1 -> RUN. Otherwise the timeout counter increments.
- Timeout: counter reaching pTIMEOUT -> seq_error=1, IDLE, no seq_done.
- RUN: trig_out=1. On the first cycle with aes_busy=0:
  - last_ct<=aes_dout; enc_count<=enc_count+1.
  - Next pt: mode0 unchanged; mode1 pt<=aes_dout; mode2 pt<=pt+1 mod 2^128.
  - If enc_count+1==count -> IDLE with seq_done=1 for one cycle.
  - Else if gap==0 -> LOAD; else GAP.
- GAP: counts gap cycles, then -> LOAD. Exactly gap cycles elapse between leaving RUN and entering LOAD.
- Abort (cfg_abort=1):
  - In GAP: -> IDLE immediately.
  - In LOAD, WAIT_BUSY or RUN: -> DRAIN. DRAIN waits for aes_busy=0, then -> IDLE.
  - The aborted encryption is not counted and last_ct is not updated.
  - Abort never pulses seq_done; enc_count keeps the completions made before the abort.
- aes_key and aes_din are stable from LOAD through the end of RUN.
- enc_count and last_ct hold their values in IDLE until the next accepted start.
- Asynchronous reset mid-batch returns all state to the reset values immediately; aes_load deasserts with no glitch pulse.

Test Plan:
- Count=1, mode0, key 000102…0f, pt 00112233…ff -> one aes_load pulse; last_ct=69c4e0d86a7b0430d8cdb78070b4c55a; enc_count=1; seq_done pulses once; trig_out high only while aes_busy.
- Count=3, gap=5, mode2, pt=ff…ff -> aes_din sequence ff…ff, 00…00, 00…01; exactly 5 cycles from RUN exit to each LOAD; enc_count=3.
- Count=2, gap=0, mode1 -> second aes_din equals first ciphertext; the LOAD follows the RUN exit on the next cycle.
- Count=0 -> seq_done pulses 1 cycle after start; no aes_load; enc_count=0. Start with abort asserted the same cycle -> ignored. Start while seq_busy -> ignored.
- Abort asserted in RUN of encryption 2 of 4 -> DRAIN until busy falls, then IDLE; enc_count=1; no seq_done. A subsequent start runs normally.
- Stub core never raising busy -> seq_error=1 after pTIMEOUT cycles, IDLE, no seq_done; next start clears seq_error. Reset mid-RUN -> all outputs return to zero.

Source files
------------

// File: rtl/aes_batch_sequencer.sv
// Batch sequencer for aes_core: runs N back-to-back AES-128 encryptions with a
// programmable idle gap, chaining/incrementing plaintext and driving the capture trigger.
module aes_batch_sequencer #(
    parameter int pCNT_WIDTH = 16,
    parameter int pGAP_WIDTH = 16,
    parameter int pTIMEOUT   = 64
) (
    input  logic                  dut_clk,
    input  logic                  dut_rst_n,
    input  logic                  cfg_start,
    input  logic                  cfg_abort,
    input  logic [pCNT_WIDTH-1:0] cfg_count,
    input  logic [pGAP_WIDTH-1:0] cfg_gap,
    input  logic [1:0]            cfg_mode,
    input  logic [127:0]          cfg_key,
    input  logic [127:0]          cfg_pt,
    output logic                  aes_load,
    output logic [255:0]          aes_key,
    output logic [127:0]          aes_din,
    input  logic [127:0]          aes_dout,
    input  logic                  aes_busy,
    output logic                  seq_busy,
    output logic                  seq_done,
    output logic                  seq_error,
    output logic                  trig_out,
    output logic [pCNT_WIDTH-1:0] enc_count,
    output logic [127:0]          last_ct
);
    localparam int TO_W = $clog2(pTIMEOUT + 1);

    typedef enum logic [2:0] {S_IDLE, S_LOAD, S_WAIT, S_RUN, S_GAP, S_DRAIN} state_t;

    state_t                state_q, state_d;
    logic [pCNT_WIDTH-1:0] cnt_q, cnt_d, enc_q, enc_d, enc_nxt;
    logic [pGAP_WIDTH-1:0] gap_q, gap_d, gcnt_q, gcnt_d;
    logic [TO_W-1:0]       to_q, to_d;
    logic [1:0]            mode_q, mode_d;
    logic [127:0]          key_q, key_d, pt_q, pt_d, ct_q, ct_d;
    logic                  err_q, err_d, done_q, done_d;

    assign enc_nxt = enc_q + pCNT_WIDTH'(1);

    always_ff @(posedge dut_clk or negedge dut_rst_n) begin
        if (!dut_rst_n) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            enc_q   <= '0;
            gap_q   <= '0;
            gcnt_q  <= '0;
            to_q    <= '0;
            mode_q  <= '0;
            key_q   <= '0;
            pt_q    <= '0;
            ct_q    <= '0;
            err_q   <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            enc_q   <= enc_d;
            gap_q   <= gap_d;
            gcnt_q  <= gcnt_d;
            to_q    <= to_d;
            mode_q  <= mode_d;
            key_q   <= key_d;
            pt_q    <= pt_d;
            ct_q    <= ct_d;
            err_q   <= err_d;
            done_q  <= done_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        enc_d   = enc_q;
        gap_d   = gap_q;
        gcnt_d  = gcnt_q;
        to_d    = to_q;
        mode_d  = mode_q;
        key_d   = key_q;
        pt_d    = pt_q;
        ct_d    = ct_q;
        err_d   = err_q;
        done_d  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (cfg_start && !cfg_abort) begin
                    cnt_d  = cfg_count;
                    gap_d  = cfg_gap;
                    mode_d = (cfg_mode == 2'd3) ? 2'd0 : cfg_mode;
                    key_d  = cfg_key;
                    pt_d   = cfg_pt;
                    enc_d  = '0;
                    err_d  = 1'b0;
                    // An empty batch completes without ever touching the core
                    if (cfg_count == '0) done_d = 1'b1;
                    else                 state_d = S_LOAD;
                end
            end
            S_LOAD: begin
                to_d    = '0;
                state_d = cfg_abort ? S_DRAIN : S_WAIT;
            end
            S_WAIT: begin
                if (cfg_abort)                         state_d = S_DRAIN;
                else if (aes_busy)                     state_d = S_RUN;
                else if (to_q == TO_W'(pTIMEOUT - 1)) begin
                    err_d   = 1'b1;
                    state_d = S_IDLE;
                end else                               to_d = to_q + TO_W'(1);
            end
            S_RUN: begin
                if (cfg_abort) state_d = S_DRAIN;
                else if (!aes_busy) begin
                    ct_d  = aes_dout;
                    enc_d = enc_nxt;
                    case (mode_q)
                        2'd1:    pt_d = aes_dout;
                        2'd2:    pt_d = pt_q + 128'd1;
                        default: pt_d = pt_q;
                    endcase
                    if (enc_nxt == cnt_q) begin
                        state_d = S_IDLE;
                        done_d  = 1'b1;
                    end else if (gap_q == '0) state_d = S_LOAD;
                    else begin
                        gcnt_d  = '0;
                        state_d = S_GAP;
                    end
                end
            end
            S_GAP: begin
                if (cfg_abort)                                  state_d = S_IDLE;
                else if (gcnt_q == gap_q - pGAP_WIDTH'(1))     state_d = S_LOAD;
                else                                            gcnt_d = gcnt_q + pGAP_WIDTH'(1);
            end
            S_DRAIN: begin
                if (!aes_busy) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Outputs decode straight from registers, so reset drops aes_load cleanly
    assign aes_load  = (state_q == S_LOAD);
    assign aes_key   = {key_q, 128'h0};
    assign aes_din   = pt_q;
    assign seq_busy  = (state_q != S_IDLE);
    assign seq_done  = done_q;
    assign seq_error = err_q;
    assign trig_out  = (state_q == S_RUN);
    assign enc_count = enc_q;
    assign last_ct   = ct_q;
endmodule

// File: tb/tb_aes_batch_sequencer.sv
// Directed bench for aes_batch_sequencer with a behavioural aes_core stub.
module tb_aes_batch_sequencer;
    localparam int LAT = 4;
    localparam int TO  = 64;
    localparam logic [127:0] FKEY = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] FPT  = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] FCT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

    logic         clk = 1'b0, rst_n = 1'b0;
    logic         cfg_start = 0, cfg_abort = 0;
    logic [15:0]  cfg_count = 0, cfg_gap = 0;
    logic [1:0]   cfg_mode = 0;
    logic [127:0] cfg_key = 0, cfg_pt = 0;
    logic         aes_load, aes_busy, seq_busy, seq_done, seq_error, trig_out;
    logic [255:0] aes_key;
    logic [127:0] aes_din, aes_dout, last_ct;
    logic [15:0]  enc_count;

    int checks = 0, failures = 0;

    aes_batch_sequencer #(.pCNT_WIDTH(16), .pGAP_WIDTH(16), .pTIMEOUT(TO)) dut (
        .dut_clk(clk), .dut_rst_n(rst_n), .cfg_start(cfg_start), .cfg_abort(cfg_abort),
        .cfg_count(cfg_count), .cfg_gap(cfg_gap), .cfg_mode(cfg_mode), .cfg_key(cfg_key),
        .cfg_pt(cfg_pt), .aes_load(aes_load), .aes_key(aes_key), .aes_din(aes_din),
        .aes_dout(aes_dout), .aes_busy(aes_busy), .seq_busy(seq_busy), .seq_done(seq_done),
        .seq_error(seq_error), .trig_out(trig_out), .enc_count(enc_count), .last_ct(last_ct)
    );

    always #5 clk = ~clk;

    function automatic logic [127:0] stub_ct(input logic [127:0] d, input logic [127:0] k);
        if (d == FPT && k == FKEY) return FCT;
        return {d[119:0], d[127:120]} ^ k ^ 128'ha5a5a5a5_5a5a5a5a_a5a5a5a5_5a5a5a5a;
    endfunction

    // aes_core stub: busy for LAT cycles after a load, ciphertext appears as busy falls
    logic         stub_en = 1'b1;
    int           lat;
    logic [127:0] pend;
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            aes_busy <= 1'b0; aes_dout <= '0; lat <= 0; pend <= '0;
        end else if (aes_busy) begin
            if (lat == 1) begin aes_busy <= 1'b0; aes_dout <= pend; end
            else lat <= lat - 1;
        end else if (aes_load && stub_en) begin
            aes_busy <= 1'b1; lat <= LAT; pend <= stub_ct(aes_din, aes_key[255:128]);
        end
    end

    // Monotonic monitor; tasks work with deltas against snapshots
    int           cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;
    int           load_cnt = 0, done_cnt = 0, trig_cnt = 0, exit_cyc = 0, load_cyc = 0;
    logic         trig_prev = 1'b0;
    logic [127:0] din_log [0:63];
    int           gap_log [0:63];
    always @(negedge clk) begin
        trig_prev <= trig_out;
        if (trig_prev && !trig_out) exit_cyc <= cyc;
        if (aes_load) begin
            din_log[load_cnt] <= aes_din;
            gap_log[load_cnt] <= (trig_prev && !trig_out) ? 0 : cyc - exit_cyc;
            load_cyc          <= cyc;
            load_cnt          <= load_cnt + 1;
        end
        if (seq_done) done_cnt <= done_cnt + 1;
        if (trig_out) trig_cnt <= trig_cnt + 1;
    end

    task automatic do_start(input logic [15:0] cnt, input logic [15:0] gap, input logic [1:0] mode,
                            input logic [127:0] key, input logic [127:0] pt);
        @(negedge clk);
        cfg_count = cnt; cfg_gap = gap; cfg_mode = mode; cfg_key = key; cfg_pt = pt;
        cfg_start = 1'b1;
        @(negedge clk);
        cfg_start = 1'b0;
    endtask

    task automatic wait_idle(input string name);
        int n = 0;
        while (seq_busy && n < 2000) begin @(negedge clk); n++; end
        if (seq_busy) begin
            checks++; failures++;
            $display("FAIL %s: still busy after %0d cycles, required idle", name, n);
        end
        @(negedge clk);
        @(negedge clk);
    endtask

    task automatic test_reset;
        checks++;
        if ({aes_load, seq_busy, seq_done, seq_error, trig_out} !== 5'b0) begin
            failures++; $display("FAIL reset_flags: got %b required 00000",
                                 {aes_load, seq_busy, seq_done, seq_error, trig_out});
        end
        checks++;
        if (aes_key !== 256'h0 || aes_din !== 128'h0) begin
            failures++; $display("FAIL reset_data: key=%h din=%h required 0", aes_key, aes_din);
        end
        checks++;
        if (enc_count !== 16'h0 || last_ct !== 128'h0) begin
            failures++; $display("FAIL reset_cnt: enc=%0d ct=%h required 0", enc_count, last_ct);
        end
    endtask

    task automatic test_single;
        int l0 = load_cnt, d0 = done_cnt, t0 = trig_cnt;
        do_start(16'd1, 16'd0, 2'd0, FKEY, FPT);
        wait_idle("single");
        checks++;
        if (load_cnt - l0 != 1) begin failures++; $display("FAIL single_loads: got %0d required 1", load_cnt - l0); end
        checks++;
        if (last_ct !== FCT) begin failures++; $display("FAIL single_ct: got %h required %h", last_ct, FCT); end
        checks++;
        if (enc_count !== 16'd1) begin failures++; $display("FAIL single_enc: got %0d required 1", enc_count); end
        checks++;
        if (done_cnt - d0 != 1) begin failures++; $display("FAIL single_done: got %0d required 1", done_cnt - d0); end
        checks++;
        if (trig_cnt - t0 != LAT) begin failures++; $display("FAIL single_trig: got %0d required %0d", trig_cnt - t0, LAT); end
        checks++;
        if (aes_key !== {FKEY, 128'h0}) begin failures++; $display("FAIL single_key: got %h required %h", aes_key, {FKEY, 128'h0}); end
    endtask

    task automatic test_increment;
        int l0 = load_cnt, d0 = done_cnt;
        do_start(16'd3, 16'd5, 2'd2, FKEY, {128{1'b1}});
        wait_idle("incr");
        checks++;
        if (load_cnt - l0 != 3) begin failures++; $display("FAIL incr_loads: got %0d required 3", load_cnt - l0); end
        checks++;
        if (din_log[l0] !== {128{1'b1}} || din_log[l0+1] !== 128'h0 || din_log[l0+2] !== 128'h1) begin
            failures++; $display("FAIL incr_din: got %h %h %h required ff.. 0 1", din_log[l0], din_log[l0+1], din_log[l0+2]);
        end
        checks++;
        if (gap_log[l0+1] != 5 || gap_log[l0+2] != 5) begin
            failures++; $display("FAIL incr_gap: got %0d %0d required 5 5", gap_log[l0+1], gap_log[l0+2]);
        end
        checks++;
        if (enc_count !== 16'd3 || done_cnt - d0 != 1) begin
            failures++; $display("FAIL incr_enc: got enc=%0d done=%0d required 3 1", enc_count, done_cnt - d0);
        end
        checks++;
        if (last_ct !== stub_ct(128'h1, FKEY)) begin failures++; $display("FAIL incr_ct: got %h required %h", last_ct, stub_ct(128'h1, FKEY)); end
    endtask

    task automatic test_chain;
        logic [127:0] p  = 128'h0123456789abcdeffedcba9876543210;
        logic [127:0] k  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
        logic [127:0] c1 = stub_ct(p, k);
        int l0 = load_cnt;
        do_start(16'd2, 16'd0, 2'd1, k, p);
        wait_idle("chain");
        checks++;
        if (din_log[l0+1] !== c1) begin failures++; $display("FAIL chain_din: got %h required %h", din_log[l0+1], c1); end
        checks++;
        if (gap_log[l0+1] != 0) begin failures++; $display("FAIL chain_gap: got %0d required 0", gap_log[l0+1]); end
        checks++;
        if (last_ct !== stub_ct(c1, k) || enc_count !== 16'd2) begin
            failures++; $display("FAIL chain_end: got ct=%h enc=%0d required %h 2", last_ct, enc_count, stub_ct(c1, k));
        end
    endtask

    task automatic test_zero_and_ignored;
        int l0 = load_cnt, d0;
        do_start(16'd0, 16'd0, 2'd0, FKEY, FPT);
        checks++;
        if (seq_done !== 1'b1 || seq_busy !== 1'b0) begin
            failures++; $display("FAIL zero_done: got done=%b busy=%b required 1 0", seq_done, seq_busy);
        end
        @(negedge clk);
        checks++;
        if (load_cnt != l0 || enc_count !== 16'd0 || seq_done !== 1'b0) begin
            failures++; $display("FAIL zero_state: got loads=%0d enc=%0d done=%b required 0 0 0", load_cnt - l0, enc_count, seq_done);
        end
        d0 = done_cnt;
        cfg_abort = 1'b1;
        do_start(16'd1, 16'd0, 2'd0, FKEY, FPT);
        cfg_abort = 1'b0;
        @(negedge clk);
        checks++;
        if (seq_busy !== 1'b0 || load_cnt != l0 || done_cnt != d0) begin
            failures++; $display("FAIL start_abort: got busy=%b loads=%0d required 0 0", seq_busy, load_cnt - l0);
        end
        do_start(16'd2, 16'd3, 2'd0, FKEY, FPT);
        repeat (3) @(negedge clk);
        do_start(16'd5, 16'd3, 2'd0, FKEY, FPT);
        wait_idle("busy_start");
        checks++;
        if (enc_count !== 16'd2 || load_cnt - l0 != 2) begin
            failures++; $display("FAIL busy_start: got enc=%0d loads=%0d required 2 2", enc_count, load_cnt - l0);
        end
    endtask

    task automatic test_abort;
        logic [127:0] p = 128'hdeadbeef_00000000_cafef00d_12345678;
        int l0 = load_cnt, d0 = done_cnt, n = 0;
        do_start(16'd4, 16'd2, 2'd0, FKEY, p);
        while (!(trig_out && load_cnt >= l0 + 2) && n < 500) begin @(negedge clk); n++; end
        checks++;
        if (!trig_out) begin failures++; $display("FAIL abort_reach: trig=%b required 1", trig_out); end
        cfg_abort = 1'b1;
        @(negedge clk);
        cfg_abort = 1'b0;
        checks++;
        if (seq_busy !== 1'b1 || trig_out !== 1'b0 || aes_busy !== 1'b1) begin
            failures++; $display("FAIL abort_drain: got busy=%b trig=%b core=%b required 1 0 1", seq_busy, trig_out, aes_busy);
        end
        wait_idle("abort");
        checks++;
        if (enc_count !== 16'd1 || done_cnt != d0 || last_ct !== stub_ct(p, FKEY)) begin
            failures++; $display("FAIL abort_end: got enc=%0d done=%0d ct=%h required 1 0 %h", enc_count, done_cnt - d0, last_ct, stub_ct(p, FKEY));
        end
        d0 = done_cnt;
        do_start(16'd1, 16'd0, 2'd0, FKEY, FPT);
        wait_idle("post_abort");
        checks++;
        if (enc_count !== 16'd1 || done_cnt - d0 != 1 || last_ct !== FCT) begin
            failures++; $display("FAIL post_abort: got enc=%0d done=%0d ct=%h required 1 1 %h", enc_count, done_cnt - d0, last_ct, FCT);
        end
    endtask

    task automatic test_timeout;
        int d0 = done_cnt, n = 0;
        stub_en = 1'b0;
        do_start(16'd1, 16'd0, 2'd0, FKEY, FPT);
        while (!seq_error && n < 500) begin @(negedge clk); n++; end
        checks++;
        if (cyc - load_cyc != TO + 1) begin
            failures++; $display("FAIL timeout_lat: got %0d required %0d", cyc - load_cyc, TO + 1);
        end
        @(negedge clk);
        checks++;
        if (seq_error !== 1'b1 || seq_busy !== 1'b0 || done_cnt != d0) begin
            failures++; $display("FAIL timeout_state: got err=%b busy=%b done=%0d required 1 0 0", seq_error, seq_busy, done_cnt - d0);
        end
        stub_en = 1'b1;
        do_start(16'd1, 16'd0, 2'd0, FKEY, FPT);
        checks++;
        if (seq_error !== 1'b0) begin failures++; $display("FAIL timeout_clear: got %b required 0", seq_error); end
        wait_idle("timeout_rerun");
    endtask

    task automatic test_reset_mid;
        int n = 0;
        do_start(16'd3, 16'd1, 2'd2, FKEY, FPT);
        while (!trig_out && n < 200) begin @(negedge clk); n++; end
        rst_n = 1'b0;
        #1;
        checks++;
        if ({aes_load, seq_busy, seq_done, seq_error, trig_out} !== 5'b0 || aes_key !== 256'h0 ||
            aes_din !== 128'h0 || enc_count !== 16'h0 || last_ct !== 128'h0) begin
            failures++; $display("FAIL reset_mid: flags=%b key=%h din=%h enc=%0d ct=%h required all 0",
                                 {aes_load, seq_busy, seq_done, seq_error, trig_out}, aes_key, aes_din, enc_count, last_ct);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        test_reset;
        rst_n = 1'b1;
        @(negedge clk);
        test_single;
        test_increment;
        test_chain;
        test_zero_and_ignored;
        test_abort;
        test_timeout;
        test_reset_mid;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
